// File: rtl/mem_bank_pipe.sv
// rtl/mem_bank_pipe.sv - byte-addressed data memory with lane enables, pipelined reads and error strobes
module mem_bank_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [DATA_W-1:0]     memIn,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_W-1:0]     memOut,
  output logic                  rvalid,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] OFF_MASK = 32'(NB - 1);

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("mem_bank_pipe: READ_LAT must be within 1..4");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
      $error("mem_bank_pipe: DATA_W must be a multiple of 8, at least 8");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]   word_idx;
  logic [AW-1:0] idx;
  logic [1:0]    code;
  logic          rd_ok;
  logic          wr_ok;

  // Full 32-bit compare on the word index so high address bits never alias into range.
  assign word_idx = address >> OFF;
  assign idx      = word_idx[AW-1:0];

  always_comb begin
    code = 2'd0;
    if (read && write)
      code = 2'd3;
    else if (read || write) begin
      if ((address & OFF_MASK) != 32'd0)
        code = 2'd1;
      else if (word_idx >= 32'(DEPTH))
        code = 2'd2;
    end
  end

  assign rd_ok = !reset && read  && !write && (code == 2'd0);
  assign wr_ok = !reset && write && !read  && (code == 2'd0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= memIn[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      err      <= (code != 2'd0);
      err_code <= code;
    end
  end

  // Each stage only loads on a valid input, so the last stage doubles as the hold register for memOut.
  logic [READ_LAT-1:0] pv;
  logic [DATA_W-1:0]   pd [READ_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int k = 0; k < READ_LAT; k++)
        pd[k] <= '0;
    end else begin
      pv[0] <= rd_ok;
      if (rd_ok)
        pd[0] <= mem[idx];
      for (int k = 1; k < READ_LAT; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1])
          pd[k] <= pd[k-1];
      end
    end
  end

  assign memOut = pd[READ_LAT-1];
  assign rvalid = pv[READ_LAT-1];

endmodule

// File: tb/tb_mem_bank_pipe.sv
// tb/tb_mem_bank_pipe.sv - directed bench for mem_bank_pipe at READ_LAT 1 and 3 sharing one stimulus
module tb_mem_bank_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] memIn = '0;
  logic [3:0]  be = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;

  logic [31:0] m1, m3;
  logic        rv1, rv3, err1, err3;
  logic [1:0]  code1, code3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_bank_pipe #(.DATA_W(32), .DEPTH(256), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .address(address), .memIn(memIn), .be(be),
    .read(read), .write(write), .memOut(m1), .rvalid(rv1), .err(err1), .err_code(code1)
  );

  mem_bank_pipe #(.DATA_W(32), .DEPTH(256), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .address(address), .memIn(memIn), .be(be),
    .read(read), .write(write), .memOut(m3), .rvalid(rv3), .err(err3), .err_code(code3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    read = r; write = w; address = a; memIn = d; be = b;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    checks++; if (rv1 !== 1'b0) begin fails++; $display("FAIL rst_rv1 got %b want 0", rv1); end
    checks++; if (rv3 !== 1'b0) begin fails++; $display("FAIL rst_rv3 got %b want 0", rv3); end
    checks++; if (m1 !== 32'h0) begin fails++; $display("FAIL rst_m1 got %h want 0", m1); end
    checks++; if (m3 !== 32'h0) begin fails++; $display("FAIL rst_m3 got %h want 0", m3); end
    checks++; if ({err1, code1} !== 3'b000) begin fails++; $display("FAIL rst_err got %b/%0d want 0/0", err1, code1); end
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    set_req(1'b0, 1'b1, 32'd16, 32'h12345678, 4'hF); tick();
    set_req(1'b0, 1'b1, 32'd24, 32'h89abcdef, 4'hF); tick();
    set_req(1'b0, 1'b1, 32'd20, 32'h00000000, 4'hF); tick();
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL def_r16_lat1 got %b/%h want 1/12345678", rv1, m1); end
    checks++; if (rv3 !== 1'b0) begin fails++; $display("FAIL def_lat3_early got %b want 0", rv3); end
    set_req(1'b1, 1'b0, 32'd20, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'h00000000}) begin fails++; $display("FAIL def_r20_lat1 got %b/%h want 1/00000000", rv1, m1); end
    set_req(1'b1, 1'b0, 32'd24, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'h89abcdef}) begin fails++; $display("FAIL def_r24_lat1 got %b/%h want 1/89abcdef", rv1, m1); end
    checks++; if ({rv3, m3} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL def_r16_lat3 got %b/%h want 1/12345678", rv3, m3); end
    idle(); tick();
    checks++; if ({rv1, m1} !== {1'b0, 32'h89abcdef}) begin fails++; $display("FAIL def_hold_lat1 got %b/%h want 0/89abcdef", rv1, m1); end
    checks++; if ({rv3, m3} !== {1'b1, 32'h00000000}) begin fails++; $display("FAIL def_r20_lat3 got %b/%h want 1/00000000", rv3, m3); end
    tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h89abcdef}) begin fails++; $display("FAIL def_r24_lat3 got %b/%h want 1/89abcdef", rv3, m3); end
    tick();
    checks++; if ({rv3, m3} !== {1'b0, 32'h89abcdef}) begin fails++; $display("FAIL def_hold_lat3 got %b/%h want 0/89abcdef", rv3, m3); end
  endtask

  task automatic test_byte_enable();
    set_req(1'b0, 1'b1, 32'd16, 32'hAABBCCDD, 4'b0101); tick();
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'h12BB56DD}) begin fails++; $display("FAIL be_lat1 got %b/%h want 1/12bb56dd", rv1, m1); end
    idle(); tick(); tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h12BB56DD}) begin fails++; $display("FAIL be_lat3 got %b/%h want 1/12bb56dd", rv3, m3); end
    set_req(1'b0, 1'b1, 32'd16, 32'hFFFFFFFF, 4'h0); tick();
    checks++; if (err1 !== 1'b0) begin fails++; $display("FAIL be_zero_err got %b want 0", err1); end
    set_req(1'b0, 1'b1, 32'd16, 32'h12345678, 4'hF); tick();
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_errors();
    set_req(1'b1, 1'b0, 32'd18, 32'h0, 4'h0); tick();
    checks++; if ({err1, code1} !== 3'b1_01) begin fails++; $display("FAIL err_misal got %b/%0d want 1/1", err1, code1); end
    checks++; if (rv1 !== 1'b0) begin fails++; $display("FAIL err_misal_rv1 got %b want 0", rv1); end
    idle(); tick();
    checks++; if ({err1, code1} !== 3'b0_00) begin fails++; $display("FAIL err_idle got %b/%0d want 0/0", err1, code1); end
    tick();
    checks++; if (rv3 !== 1'b0) begin fails++; $display("FAIL err_misal_rv3 got %b want 0", rv3); end
    set_req(1'b1, 1'b0, 32'd1024, 32'h0, 4'h0); tick();
    checks++; if ({err1, code1, rv1} !== 4'b1_10_0) begin fails++; $display("FAIL err_range got %b/%0d/%b want 1/2/0", err1, code1, rv1); end
    checks++; if ({err3, code3} !== 3'b1_10) begin fails++; $display("FAIL err_range_lat3 got %b/%0d want 1/2", err3, code3); end
    set_req(1'b1, 1'b0, 32'd1020, 32'h0, 4'h0); tick();
    checks++; if ({err1, rv1} !== 2'b01) begin fails++; $display("FAIL err_top_word got %b/%b want 0/1", err1, rv1); end
    set_req(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0); tick();
    checks++; if ({err1, code1} !== 3'b1_10) begin fails++; $display("FAIL err_alias got %b/%0d want 1/2", err1, code1); end
    set_req(1'b0, 1'b1, 32'd17, 32'h0, 4'hF); tick();
    checks++; if ({err1, code1} !== 3'b1_01) begin fails++; $display("FAIL err_wr_misal got %b/%0d want 1/1", err1, code1); end
    set_req(1'b1, 1'b1, 32'd16, 32'hDEADBEEF, 4'hF); tick();
    checks++; if ({err1, code1} !== 3'b1_11) begin fails++; $display("FAIL err_rw got %b/%0d want 1/3", err1, code1); end
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL err_rw_unchanged got %b/%h want 1/12345678", rv1, m1); end
    idle(); tick(); tick();
  endtask

  task automatic test_lat3_reject();
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    set_req(1'b1, 1'b0, 32'd18, 32'h0, 4'h0); tick();
    checks++; if ({err3, code3} !== 3'b1_01) begin fails++; $display("FAIL l3_reject got %b/%0d want 1/1", err3, code3); end
    set_req(1'b1, 1'b0, 32'd24, 32'h0, 4'h0); tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL l3_first got %b/%h want 1/12345678", rv3, m3); end
    set_req(1'b1, 1'b0, 32'd20, 32'h0, 4'h0); tick();
    checks++; if ({rv3, m3} !== {1'b0, 32'h12345678}) begin fails++; $display("FAIL l3_gap got %b/%h want 0/12345678", rv3, m3); end
    idle(); tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h89abcdef}) begin fails++; $display("FAIL l3_second got %b/%h want 1/89abcdef", rv3, m3); end
    tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h00000000}) begin fails++; $display("FAIL l3_third got %b/%h want 1/00000000", rv3, m3); end
    tick();
    checks++; if (rv3 !== 1'b0) begin fails++; $display("FAIL l3_drain got %b want 0", rv3); end
  endtask

  task automatic test_reset_midflight();
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    reset = 1'b1;
    set_req(1'b1, 1'b0, 32'd18, 32'h0, 4'h0); tick();
    reset = 1'b0;
    checks++; if ({rv1, rv3, err1, err3} !== 4'b0000) begin fails++; $display("FAIL mid_rst_flags got %b%b%b%b want 0000", rv1, rv3, err1, err3); end
    checks++; if ({m1, m3} !== 64'h0) begin fails++; $display("FAIL mid_rst_data got %h/%h want 0/0", m1, m3); end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({rv3, err1} !== 2'b00) begin fails++; $display("FAIL mid_rst_ghost%0d got %b/%b want 0/0", i, rv3, err1); end
    end
    checks++; if (m3 !== 32'h0) begin fails++; $display("FAIL mid_rst_m3 got %h want 0", m3); end
    set_req(1'b1, 1'b0, 32'd16, 32'h0, 4'h0); tick();
    idle(); tick(); tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL mid_rst_readback got %b/%h want 1/12345678", rv3, m3); end
  endtask

  task automatic test_write_then_read();
    set_req(1'b0, 1'b1, 32'd32, 32'hCAFEF00D, 4'hF); tick();
    set_req(1'b1, 1'b0, 32'd32, 32'h0, 4'h0); tick();
    checks++; if ({rv1, m1} !== {1'b1, 32'hCAFEF00D}) begin fails++; $display("FAIL wtr_lat1 got %b/%h want 1/cafef00d", rv1, m1); end
    idle(); tick();
    checks++; if (rv3 !== 1'b0) begin fails++; $display("FAIL wtr_lat3_early got %b want 0", rv3); end
    tick();
    checks++; if ({rv3, m3} !== {1'b1, 32'hCAFEF00D}) begin fails++; $display("FAIL wtr_lat3 got %b/%h want 1/cafef00d", rv3, m3); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_byte_enable();
    test_errors();
    test_lat3_reject();
    test_reset_midflight();
    test_write_then_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
